// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one external Alu between two requesters. Round-robin grant in IDLE,
//   registered operands launched to the Alu, result captured exactly ALU_LAT
//   clock edges after the accept edge, then held in a per-requester response
//   register until that requester consumes it. One operation is in flight at a
//   time (IDLE -> EXEC -> RESP -> IDLE).
//
// Ports
//   clk, rst_n                     clock (rising edge), async active-low reset
//   reqN_valid/ready               requester N operation handshake (N = 0, 1)
//   reqN_a/b/sel                   requester N operands and opcode
//   rspN_valid/ready               requester N result handshake
//   rspN_out/cout/z                requester N result, carry, zero flag
//   alu_a/alu_b/alu_sel            registered operands driven to the Alu
//   alu_out/alu_cout/alu_z         Alu result, sampled at the end of EXEC
//   busy                           high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH   = 32,
    parameter int SEL_W   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [SEL_W-1:0] req0_sel,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [SEL_W-1:0] req1_sel,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_out,
    output logic             rsp0_cout,
    output logic             rsp0_z,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_out,
    output logic             rsp1_cout,
    output logic             rsp1_z,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_cout,
    input  logic             alu_z,

    output logic             busy
);

    // lat_cnt only ever holds ALU_LAT-1 down to 0.
    localparam int                CNT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CNT_W-1:0]  LAT_INIT = CNT_W'(ALU_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             last_grant;   // 1 = requester 1 was served last
    logic             owner;        // requester owning the op in flight
    logic [CNT_W-1:0] lat_cnt;

    logic             gnt0;
    logic             gnt1;
    logic             accept;
    logic             rsp_hs;

    // Round-robin: under contention the requester that was not served last
    // wins; a lone requester always wins, so it can be served back-to-back.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt0 = last_grant;
            gnt1 = !last_grant;
        end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
        end
    end

    // Ready is forced low during reset so every output reads 0 while rst_n is low.
    assign req0_ready = rst_n && (state_q == IDLE) && gnt0;
    assign req1_ready = rst_n && (state_q == IDLE) && gnt1;
    assign accept     = (state_q == IDLE) && (gnt0 || gnt1);
    assign rsp_hs     = owner ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready);
    assign busy       = (state_q != IDLE);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)        state_d = EXEC;
            EXEC:    if (lat_cnt == '0) state_d = RESP;
            RESP:    if (rsp_hs)        state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Datapath: operand launch, result capture, response handshake.
    // NOTE: every datapath/output register is reset here because all outputs
    // must read 0 during reset; there is no memory array to leave un-reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            lat_cnt    <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            rsp0_valid <= 1'b0;
            rsp0_out   <= '0;
            rsp0_cout  <= 1'b0;
            rsp0_z     <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_out   <= '0;
            rsp1_cout  <= 1'b0;
            rsp1_z     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        // alu_* then stay frozen until the next accept.
                        alu_a   <= gnt0 ? req0_a   : req1_a;
                        alu_b   <= gnt0 ? req0_b   : req1_b;
                        alu_sel <= gnt0 ? req0_sel : req1_sel;
                        owner   <= gnt1;
                        lat_cnt <= LAT_INIT;
                    end
                end
                EXEC: begin
                    if (lat_cnt == '0) begin
                        if (owner) begin
                            rsp1_out   <= alu_out;
                            rsp1_cout  <= alu_cout;
                            rsp1_z     <= alu_z;
                            rsp1_valid <= 1'b1;
                        end else begin
                            rsp0_out   <= alu_out;
                            rsp0_cout  <= alu_cout;
                            rsp0_z     <= alu_z;
                            rsp0_valid <= 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        last_grant <= owner;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//   Two arbiter instances: u_lat1 (ALU_LAT=1, Alu stub combinational with an
//   optional fixed-result override) and u_lat3 (ALU_LAT=3, Alu stub pipelined
//   two registers deep). Stimulus pushes expected results into per-requester
//   queues at the accept edge; a monitor pops and compares on every response
//   handshake and checks launch-to-capture latency when rsp valid rises.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    typedef struct {
        logic [31:0] out;
        logic        cout;
        logic        z;
        int          acc;     // cycle count right after the accept edge
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // [instance][requester]; instance 0 = u_lat1, instance 1 = u_lat3
    logic        req_valid [2][2];
    logic        req_ready [2][2];
    logic [31:0] req_a     [2][2];
    logic [31:0] req_b     [2][2];
    logic [3:0]  req_sel   [2][2];
    logic        rsp_valid [2][2];
    logic        rsp_ready [2][2];
    logic [31:0] rsp_out   [2][2];
    logic        rsp_cout  [2][2];
    logic        rsp_z     [2][2];

    logic [31:0] alu1_a, alu1_b, alu1_out, alu3_a, alu3_b, alu3_out;
    logic [3:0]  alu1_sel, alu3_sel;
    logic        alu1_cout, alu1_z, alu3_cout, alu3_z, busy1, busy3;
    logic        stub = 1'b0;
    logic [33:0] p1, p2;

    exp_t        exp_q [2][2][$];
    int          last_acc [2][2];
    int          grant_log [$];
    int          lat_of [2] = '{1, 3};
    logic        prev_valid [2][2];
    logic [31:0] exp_alu_a, exp_alu_b;
    logic [3:0]  exp_alu_sel;
    logic        alu_armed = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference Alu: returns {cout, z, out}.
    function automatic logic [33:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] sel);
        logic [32:0] r;
        case (sel)
            4'h0:    r = {1'b0, a & b};
            4'h1:    r = {1'b0, a | b};
            4'h2:    r = {1'b0, a} + {1'b0, b};
            4'h6:    r = {1'b0, a} - {1'b0, b};
            default: r = {1'b0, a ^ b};
        endcase
        return {r[32], (r[31:0] == 32'h0), r[31:0]};
    endfunction

    always_comb begin
        if (stub) {alu1_cout, alu1_z, alu1_out} = {1'b1, 1'b1, 32'h0};
        else      {alu1_cout, alu1_z, alu1_out} = alu_f(alu1_a, alu1_b, alu1_sel);
    end

    always @(posedge clk) begin
        p1 <= alu_f(alu3_a, alu3_b, alu3_sel);
        p2 <= p1;
    end
    assign {alu3_cout, alu3_z, alu3_out} = p2;

    alu_arbiter #(.WIDTH(32), .SEL_W(4), .ALU_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req_valid[0][0]), .req0_ready(req_ready[0][0]),
        .req0_a(req_a[0][0]), .req0_b(req_b[0][0]), .req0_sel(req_sel[0][0]),
        .req1_valid(req_valid[0][1]), .req1_ready(req_ready[0][1]),
        .req1_a(req_a[0][1]), .req1_b(req_b[0][1]), .req1_sel(req_sel[0][1]),
        .rsp0_valid(rsp_valid[0][0]), .rsp0_ready(rsp_ready[0][0]),
        .rsp0_out(rsp_out[0][0]), .rsp0_cout(rsp_cout[0][0]), .rsp0_z(rsp_z[0][0]),
        .rsp1_valid(rsp_valid[0][1]), .rsp1_ready(rsp_ready[0][1]),
        .rsp1_out(rsp_out[0][1]), .rsp1_cout(rsp_cout[0][1]), .rsp1_z(rsp_z[0][1]),
        .alu_a(alu1_a), .alu_b(alu1_b), .alu_sel(alu1_sel),
        .alu_out(alu1_out), .alu_cout(alu1_cout), .alu_z(alu1_z),
        .busy(busy1)
    );

    alu_arbiter #(.WIDTH(32), .SEL_W(4), .ALU_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req_valid[1][0]), .req0_ready(req_ready[1][0]),
        .req0_a(req_a[1][0]), .req0_b(req_b[1][0]), .req0_sel(req_sel[1][0]),
        .req1_valid(req_valid[1][1]), .req1_ready(req_ready[1][1]),
        .req1_a(req_a[1][1]), .req1_b(req_b[1][1]), .req1_sel(req_sel[1][1]),
        .rsp0_valid(rsp_valid[1][0]), .rsp0_ready(rsp_ready[1][0]),
        .rsp0_out(rsp_out[1][0]), .rsp0_cout(rsp_cout[1][0]), .rsp0_z(rsp_z[1][0]),
        .rsp1_valid(rsp_valid[1][1]), .rsp1_ready(rsp_ready[1][1]),
        .rsp1_out(rsp_out[1][1]), .rsp1_cout(rsp_cout[1][1]), .rsp1_z(rsp_z[1][1]),
        .alu_a(alu3_a), .alu_b(alu3_b), .alu_sel(alu3_sel),
        .alu_out(alu3_out), .alu_cout(alu3_cout), .alu_z(alu3_z),
        .busy(busy3)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input string msg);
        checks++;
        errors++;
        $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
    endtask

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic issue(input int i, input int r, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] sel, input logic [33:0] exp);
        exp_t e;
        int   n = 0;
        req_a[i][r] = a;
        req_b[i][r] = b;
        req_sel[i][r] = sel;
        req_valid[i][r] = 1'b1;
        forever begin
            #1;
            if (req_ready[i][r]) break;
            @(negedge clk);
            n++;
            if (n > 200) begin
                fail("req_ready_timeout", $sformatf("inst %0d req %0d never granted", i, r));
                req_valid[i][r] = 1'b0;
                return;
            end
        end
        e.out = exp[31:0];
        e.cout = exp[33];
        e.z = exp[32];
        e.acc = cyc + 1;
        exp_q[i][r].push_back(e);
        last_acc[i][r] = cyc + 1;
        if (i == 0) grant_log.push_back(r);
        @(negedge clk);
        req_valid[i][r] = 1'b0;
        if (i == 1) begin
            exp_alu_a = a;
            exp_alu_b = b;
            exp_alu_sel = sel;
            alu_armed = 1'b1;
        end
    endtask

    // Wait until nothing is in flight or pending on either instance.
    task automatic drain();
        int n = 0;
        logic pending;
        do begin
            @(negedge clk);
            #3;
            n++;
            pending = busy1 || busy3;
            for (int i = 0; i < 2; i++)
                for (int r = 0; r < 2; r++)
                    if (exp_q[i][r].size() != 0) pending = 1'b1;
        end while (pending && n < 500);
        if (pending) fail("drain_timeout", "responses still outstanding");
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_alu_ab"}, {alu1_a, alu1_b}, 64'h0);
        check({tag, "_ctl"}, {alu1_sel, busy1, req_ready[0][0], req_ready[0][1],
                              rsp_valid[0][0], rsp_valid[0][1]}, 64'h0);
        check({tag, "_rsp_out"}, {rsp_out[0][0], rsp_out[0][1]}, 64'h0);
        check({tag, "_rsp_flags"}, {rsp_cout[0][0], rsp_z[0][0],
                                    rsp_cout[0][1], rsp_z[0][1]}, 64'h0);
    endtask

    // Monitor: latency on valid rise, data on handshake, Alu operand stability.
    always begin
        @(negedge clk);
        #2;
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (rst_n) begin
                    if (rsp_valid[i][r] && !prev_valid[i][r]) begin
                        if (exp_q[i][r].size() == 0)
                            fail("unexpected_rsp", $sformatf("inst %0d rsp%0d valid with nothing issued", i, r));
                        else
                            check($sformatf("latency_i%0d_r%0d", i, r),
                                  64'(cyc - exp_q[i][r][0].acc), 64'(lat_of[i]));
                    end
                    if (rsp_valid[i][r] && rsp_ready[i][r] && exp_q[i][r].size() != 0) begin
                        exp_t e;
                        e = exp_q[i][r].pop_front();
                        check($sformatf("rsp_out_i%0d_r%0d", i, r), 64'(rsp_out[i][r]), 64'(e.out));
                        check($sformatf("rsp_flags_i%0d_r%0d", i, r),
                              {62'h0, rsp_cout[i][r], rsp_z[i][r]}, {62'h0, e.cout, e.z});
                    end
                end
                prev_valid[i][r] = rsp_valid[i][r];
            end
        end
        if (rst_n && alu_armed) begin
            check("alu3_a_stable", 64'(alu3_a), 64'(exp_alu_a));
            check("alu3_b_stable", 64'(alu3_b), 64'(exp_alu_b));
            check("alu3_sel_stable", 64'(alu3_sel), 64'(exp_alu_sel));
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int h_cyc;
        logic [31:0] a, b;
        logic [3:0]  sel;
        logic [3:0]  ops [5] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h3};

        for (int i = 0; i < 2; i++)
            for (int r = 0; r < 2; r++) begin
                req_valid[i][r] = 1'b0;
                req_a[i][r] = '0;
                req_b[i][r] = '0;
                req_sel[i][r] = '0;
                rsp_ready[i][r] = 1'b1;
                prev_valid[i][r] = 1'b0;
                last_acc[i][r] = 0;
            end

        // 1a: reset held 3 cycles with a requester asserting valid.
        req_a[0][0] = 32'h1111_2222;
        req_valid[0][0] = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_zero("reset_hold");
        req_valid[0][0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 2: single add on requester 0, ALU_LAT=1 (hand-computed result).
        issue(0, 0, 32'hABCD_EFFF, 32'h1234_5678, 4'b0010, {1'b0, 1'b0, 32'hBE02_4677});
        drain();

        // 1b: reset asserted mid-EXEC drops the op, no response afterwards.
        req_a[0][1] = 32'hDEAD_BEEF;
        req_b[0][1] = 32'h0000_0001;
        req_sel[0][1] = 4'h2;
        req_valid[0][1] = 1'b1;
        #1;
        check("midexec_grant", 64'(req_ready[0][1]), 64'h1);
        @(negedge clk);
        req_valid[0][1] = 1'b0;
        #1;
        check("midexec_busy", 64'(busy1), 64'h1);
        rst_n = 1'b0;
        #1;
        check_zero("reset_exec");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
            check("no_rsp_after_reset", {62'h0, rsp_valid[0][0], rsp_valid[0][1]}, 64'h0);
        end
        @(negedge clk);

        // 3: contention right after reset, strict alternation starting with req0.
        grant_log.delete();
        fork
            for (int k = 0; k < 4; k++)
                issue(0, 0, 32'h100 + k, 32'h10, 4'h2, alu_f(32'h100 + k, 32'h10, 4'h2));
            for (int k = 0; k < 4; k++)
                issue(0, 1, 32'hF0F0 + k, 32'h0FF, 4'h0, alu_f(32'hF0F0 + k, 32'h0FF, 4'h0));
        join
        drain();
        check("alternation_count", 64'(grant_log.size()), 64'd8);
        for (int k = 0; k < grant_log.size(); k++)
            check($sformatf("alternation_%0d", k), 64'(grant_log[k]), 64'(k % 2));

        // 4: rsp0 back-pressure for 5 cycles while req1 waits.
        rsp_ready[0][0] = 1'b0;
        issue(0, 0, 32'h0000_00F0, 32'h0000_000F, 4'h1, {1'b0, 1'b0, 32'h0000_00FF});
        fork
            issue(0, 1, 32'h5, 32'h5, 4'h6, {1'b0, 1'b1, 32'h0});
        join_none
        begin
            int n = 0;
            #1;
            while (!rsp_valid[0][0] && n < 50) begin
                @(negedge clk);
                #1;
                n++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp0_valid", 64'(rsp_valid[0][0]), 64'h1);
            check("bp_rsp0_out", 64'(rsp_out[0][0]), 64'h0000_00FF);
            check("bp_req1_ready", 64'(req_ready[0][1]), 64'h0);
            @(negedge clk);
            #1;
        end
        h_cyc = cyc;
        rsp_ready[0][0] = 1'b1;
        drain();
        check("bp_req1_accept_cycle", 64'(last_acc[0][1]), 64'(h_cyc + 2));

        // 5: Alu stub forces out=0, cout=1, z=1.
        stub = 1'b1;
        issue(0, 1, 32'h0000_1234, 32'h0000_0001, 4'h2, {1'b1, 1'b1, 32'h0});
        drain();
        stub = 1'b0;

        // 6: ALU_LAT=3 instance, 10 random ops against the pipelined Alu model.
        for (int k = 0; k < 10; k++) begin
            a = $urandom;
            b = (k == 3) ? a : $urandom;
            sel = ops[$urandom_range(0, 4)];
            issue(1, $urandom_range(0, 1), a, b, sel, alu_f(a, b, sel));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
